// File: rtl/mole_judge.sv
// Whack-a-mole judge: picks the lit hole, times its window and grades key presses as hit or miss.
// Optional MOLE_SPEEDUP_EN shrinks the visible window every 8 hits.
module mole_judge #(
  parameter int          HOLES      = 8,
  parameter int          SHOW_TICKS = 1500,
  parameter int          GAP_TICKS  = 500,
  parameter int          HOLD_TICKS = 200,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             game_en,
  input  logic [HOLES-1:0] key,
  output logic [HOLES-1:0] mole,
  output logic             getpoint,
  output logic [1:0]       p,
  output logic             miss,
  output logic [7:0]       hits
);

  // state | meaning
  // IDLE  | game stopped, no mole
  // GAP   | idle gap before the next mole
  // SHOW  | mole visible, waiting for a press or timeout
  // HOLD  | blank period after a hit or miss
  typedef enum logic [1:0] {IDLE, GAP, SHOW, HOLD} state_t;

  localparam int HB   = $clog2(HOLES);
  localparam int CMAX = (GAP_TICKS > HOLD_TICKS) ? GAP_TICKS : HOLD_TICKS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int EW   = $clog2(SHOW_TICKS + 1);
  localparam logic [HOLES-1:0] ONE = {{(HOLES-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]    elapsed_q, elapsed_d;
  logic [HB-1:0]    hole_q, hole_d;
  logic [HB-1:0]    pick;
  logic             getpoint_d, miss_d;
  logic [1:0]       p_d;
  logic [7:0]       hits_d;
  logic [15:0]      lfsr_q;
  logic [HOLES-1:0] key_q, press, target;
  logic [EW-1:0]    win_q;
  logic [EW+2:0]    e3, w1, w2;
  logic             timeout;

`ifdef MOLE_SPEEDUP_EN
  localparam logic [EW-1:0] WIN_STEP  = EW'(SHOW_TICKS / 8);
  localparam logic [EW-1:0] WIN_FLOOR = EW'(SHOW_TICKS / 4);
  logic [EW-1:0] win_d;
`else
  assign win_q = EW'(SHOW_TICKS);
`endif

  assign press  = key & ~key_q;
  assign target = ONE << hole_q;
  assign mole   = (state_q == SHOW) ? target : '0;

  // Consecutive picks never repeat a hole.
  always_comb begin
    pick = lfsr_q[HB-1:0];
    if (pick == hole_q) pick = pick + 1'b1;
  end

  // p grading as integer-division thresholds: e < w/3  <=>  3*(e+1) <= w.
  assign e3      = ({3'b000, elapsed_q} + 1'b1) * 3'd3;
  assign w1      = {3'b000, win_q};
  assign w2      = {2'b00, win_q, 1'b0};
  assign timeout = tick && (elapsed_q == win_q - 1'b1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    elapsed_d  = elapsed_q;
    hole_d     = hole_q;
    getpoint_d = 1'b0;
    miss_d     = 1'b0;
    p_d        = p;
    hits_d     = hits;
`ifdef MOLE_SPEEDUP_EN
    win_d      = win_q;
`endif
    if (!game_en) begin
      state_d = IDLE;
`ifdef MOLE_SPEEDUP_EN
      win_d   = EW'(SHOW_TICKS);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GAP;
          cnt_d   = CW'(GAP_TICKS);
        end
        GAP: begin
          if (tick) begin
            if (cnt_q == CW'(1)) begin
              state_d   = SHOW;
              hole_d    = pick;
              elapsed_d = '0;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        SHOW: begin
          if (press == target) begin
            getpoint_d = 1'b1;
            if (e3 <= w1)      p_d = 2'd3;
            else if (e3 <= w2) p_d = 2'd2;
            else               p_d = 2'd1;
            if (hits != 8'hFF) hits_d = hits + 1'b1;
`ifdef MOLE_SPEEDUP_EN
            if (hits != 8'hFF && hits[2:0] == 3'd7)
              win_d = (win_q >= WIN_FLOOR + WIN_STEP) ? win_q - WIN_STEP : WIN_FLOOR;
`endif
            state_d = HOLD;
            cnt_d   = CW'(HOLD_TICKS);
          end else if (press != '0 || timeout) begin
            miss_d  = 1'b1;
            state_d = HOLD;
            cnt_d   = CW'(HOLD_TICKS);
          end else if (tick) begin
            elapsed_d = elapsed_q + 1'b1;
          end
        end
        HOLD: begin
          if (tick) begin
            if (cnt_q == CW'(1)) begin
              state_d = GAP;
              cnt_d   = CW'(GAP_TICKS);
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      elapsed_q <= '0;
      hole_q    <= '0;
      getpoint  <= 1'b0;
      miss      <= 1'b0;
      p         <= 2'd0;
      hits      <= 8'd0;
      lfsr_q    <= LFSR_SEED;
      key_q     <= '0;
`ifdef MOLE_SPEEDUP_EN
      win_q     <= EW'(SHOW_TICKS);
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      elapsed_q <= elapsed_d;
      hole_q    <= hole_d;
      getpoint  <= getpoint_d;
      miss      <= miss_d;
      p         <= p_d;
      hits      <= hits_d;
      lfsr_q    <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      key_q     <= key;
`ifdef MOLE_SPEEDUP_EN
      win_q     <= win_d;
`endif
    end
  end

endmodule

// File: doc/mole_judge.md
Name: mole_judge

Overview:
- Upstream stage of the scoring counter. Decides which hole's mole is up and times its visible window.
- Detects key presses and classifies each mole as hit or miss.
- On a hit, emits a one-cycle getpoint pulse with a 2-bit point value p (1–3) graded by reaction speed. The score stage consumes getpoint and p directly.

Parameters:
- HOLES, 8, number of holes/keys; power of 2, range 2–16.
- SHOW_TICKS, 1500, mole visible window in ticks; must be ≥ 3.
- GAP_TICKS, 500, idle gap before each mole, in ticks; must be ≥ 1.
- HOLD_TICKS, 200, post-hit/miss blank period, in ticks; must be ≥ 1.
- LFSR_SEED, 16'hACE1, non-zero seed of the 16-bit Fibonacci LFSR (taps 16,14,13,11).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- tick, input, 1, single-cycle timebase enable (1 kHz nominal); all timers advance only on tick.
- game_en, input, 1, level; high means game running.
- key, input, HOLES, synchronized, debounced key levels; 1 = pressed.
- mole, output, HOLES, one-hot lit hole; all zero when no mole is shown.
- getpoint, output, 1, one-cycle hit pulse.
- p, output, 2, point value of the last hit; valid in the getpoint cycle and held until the next hit.
- miss, output, 1, one-cycle pulse on timeout or wrong key.
- hits, output, 8, hit count since reset; saturates at 255.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, mole=0, getpoint=0, miss=0, p=0, hits=0, LFSR=LFSR_SEED, key_q=0, prev_hole=0.
- LFSR: advances every clk cycle, except during rst.
- Key edges: key_q <= key every cycle; press = key & ~key_q. Only rising edges count, so a key held across a mole appearance never scores.
- State IDLE: mole=0. When game_en=1, go to GAP with cnt=GAP_TICKS.
- State GAP: each tick, cnt decrements. On the tick where cnt==1:
  - Pick hole h = LFSR[log2(HOLES)-1:0]; if h==prev_hole, use h+1 mod HOLES.
  - Set prev_hole=h, elapsed=0, mole=one-hot(h); go to SHOW. mole is visible from the next cycle.
- State SHOW: each tick, elapsed increments. Evaluated every cycle in this priority order:
  - press==one-hot(h): hit. getpoint=1 for one cycle; p=3 if elapsed<SHOW_TICKS/3, else 2 if elapsed<2*SHOW_TICKS/3, else 1 (integer division). hits increments (saturating). mole=0; go to HOLD.
  - press non-zero but not exactly one-hot(h), including the correct key plus any other key: miss pulse, mole=0; go to HOLD.
  - tick with elapsed==SHOW_TICKS-1: timeout, miss pulse, mole=0; go to HOLD.
  - A hit in the same cycle as the timeout tick counts as a hit.
- State HOLD: cnt=HOLD_TICKS; decrement on tick; on the tick where cnt==1, go to GAP with cnt=GAP_TICKS. Presses in HOLD and GAP are ignored.
- game_en=0 in any state: next cycle state=IDLE, mole=0. No getpoint or miss is produced in that cycle, even if a press coincides. p and hits are retained.
- Pulses: getpoint and miss are never high together and never high in consecutive cycles. p changes only in getpoint cycles.
- Reset mid-SHOW: next cycle all outputs are at reset values; no pulse.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- Defined: the effective window win starts at SHOW_TICKS. After every 8th hit (hits[2:0] wraps to 0), win decreases by SHOW_TICKS/8, floored at SHOW_TICKS/4. Timeout and the p thresholds use win in place of SHOW_TICKS. win resets on rst and on entering IDLE.
- Undefined: the window is fixed at SHOW_TICKS; no extra registers.

Test Plan:
Bench configuration: HOLES=8, SHOW_TICKS=12, GAP_TICKS=4, HOLD_TICKS=2, tick tied high.
- Appearance: rst 2 cycles, then game_en=1 → mole goes non-zero (one-hot) exactly 5 cycles after game_en rises (1 cycle to leave IDLE + 4 GAP ticks); no pulses before that.
- Graded hits:
  - Press the lit key at elapsed=2 → getpoint 1 cycle with p=3.
  - Next mole, press at elapsed=6 → p=2.
  - Next mole, press at elapsed=10 → p=1.
  - hits=3 and p stays 1 afterwards.
- Timeout and repeat: no press → miss pulse on the cycle elapsed reaches 11; mole clears; next mole appears 2+4 ticks later on a different hole than before.
- Wrong keys:
  - Press a wrong key → miss, no getpoint.
  - Press correct and wrong keys in the same cycle → miss.
  - Key held from GAP into SHOW → no hit, then timeout miss.
- Abort and saturation:
  - Drop game_en on the same cycle as a correct press → no getpoint, mole=0 next cycle, hits unchanged.
  - Force 260 hits → hits saturates at 255.
- MOLE_SPEEDUP_EN: after 8 hits the window is 11 ticks (timeout at elapsed=10); after 72 hits the window is floored at 3 ticks.
